ring_shift_master: RTL and testbench
====================================

RING_SHIFT_MASTER -- requirements
Module: ring_shift_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the ring pattern width in bits (range 2..32).
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000, the number of clk cycles per shift tick (TICK_DIV >= 2).
REQ-003 SHALL have parameter N_SLAVE, default 2, the number of shift-enable outputs (range 1..8).
REQ-004 SHALL have parameter RING_LAT, default 16, the number of ticks from a bit leaving on serial_out to that bit returning on serial_in (range 1..64).
REQ-005 SHALL have parameter INIT, default 1, the pattern loaded into the shift register at reset.
REQ-006 SHALL have these ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = advance ticks; 0 = hold.
- dir  in  1  0 = shift toward MSB; 1 = shift toward LSB.
- load_valid  in  1  load request.
- load_data  in  WIDTH  pattern to load.
- load_ready  out  1  load accept.
- serial_in  in  1  return bit from the last slave.
- serial_out  out  1  bit sent to the first slave.
- shift_en  out  N_SLAVE  per-slave shift pulse.
- leds  out  WIDTH  current pattern.
- err_flag  out  1  sticky loopback mismatch.
- err_count  out  16  loopback mismatch count.

Function
REQ-007 SHALL implement states IDLE, RUN and HOLD, with the following transitions:
- IDLE->RUN when run=1.
- RUN->HOLD when run=0.
- HOLD->RUN when run=1.
REQ-008 SHALL hold the tick counter at 0 in IDLE, increment it by 1 per cycle in RUN, and freeze it in HOLD.
REQ-009 SHALL raise the internal tick when the counter equals TICK_DIV-1 in RUN, and SHALL wrap the counter to 0 on that same edge.
REQ-010 SHALL drive every shift_en bit as the tick registered one cycle, so that all bits are high together for exactly one cycle; the first pulse is high after edge TICK_DIV following RUN entry, then repeats every TICK_DIV cycles.
REQ-011 SHALL perform the shift update on the edge ending the cycle in which shift_en is high, as follows:
- dir=0: sr <= {sr[WIDTH-2:0], serial_in} and serial_out <= sr[WIDTH-1].
- dir=1: sr <= {serial_in, sr[WIDTH-1:1]} and serial_out <= sr[0].
REQ-012 SHALL update leds to the new sr value on that same edge; leds are unchanged otherwise.
REQ-013 SHALL sample dir only at the shift edge; a dir change between ticks has no other effect.
REQ-014 SHALL drive load_ready=1 except in any cycle where shift_en is high.
REQ-015 SHALL, on load_valid & load_ready, set sr <= load_data and leds <= load_data on the next edge, and reset the tick counter to 0; the state is unchanged.
REQ-016 SHALL ignore load_valid while load_ready=0; the requester holds load_valid and the load is accepted the following cycle.
REQ-017 SHALL, when run falls in the same cycle that the tick is raised, still issue that tick's shift_en pulse and shift, then enter HOLD.

Reset
REQ-018 SHALL, on rst_n=0, immediately and asynchronously set:
- state = IDLE, counter = 0, sr = INIT[WIDTH-1:0];
- leds = 0, serial_out = 0, shift_en = 0, load_ready = 1;
- err_flag = 0, err_count = 0.
REQ-019 SHALL, on reset asserted mid-tick, discard the partial tick; after release, the first pulse follows REQ-010.

Configuration
REQ-020 SHALL, with macro RING_LOOPBACK_CHECK_EN defined, behave as follows:
- keep a RING_LAT-deep history of bits driven on serial_out;
- at each shift, after at least RING_LAT shifts since reset or the last load, compare serial_in against the bit sent RING_LAT shifts earlier;
- on mismatch, set err_flag (sticky) and increment err_count, saturating at 16'hFFFF;
- on an accepted load, clear the history, the warm-up count, err_flag and err_count.
REQ-021 SHALL, without RING_LOOPBACK_CHECK_EN, omit the history logic and tie err_flag=0 and err_count=0; the port list is identical in both builds.

Verification (WIDTH=8, TICK_DIV=4, N_SLAVE=2, RING_LAT=3, INIT=1)
REQ-022 SHALL cover reset: rst_n low mid-run -> leds=0, sr=8'h01, shift_en=0, err_count=0 with no clk edge required.
REQ-023 SHALL cover tick timing: run=1 held from reset release -> shift_en=2'b11 for 1 cycle after edge 4 following RUN entry, then every 4 cycles; run=0 -> no pulses and counter frozen.
REQ-024 SHALL cover rotation: dir=0 with serial_in=0 -> leds 8'h02, 8'h04, ... 8'h80, then 8'h00; dir=1 with load_data=8'h80 -> leds 8'h40, 8'h20, ...
REQ-025 SHALL cover load collision: load_valid=1 with load_data=8'hA5 raised in a shift_en cycle -> load_ready=0 that cycle, load accepted the next cycle, leds=8'hA5, next tick 4 cycles later.
REQ-026 SHALL cover the loopback check with the macro defined: serial_in fed from serial_out through a 3-tick delay -> err_count=0 after 20 ticks; one injected flipped return bit -> err_flag=1, err_count=1.
REQ-027 SHALL cover the macro-undefined build: the same stimulus as REQ-026 -> err_flag=0 and err_count=0 throughout.

Source files
------------

// File: rtl/ring_shift_master.sv
// ring_shift_master
//   Ring-shift master: circulates a WIDTH-bit pattern through a chain of
//   serial slaves, one bit per tick. The tick is derived from clk by a
//   TICK_DIV-cycle counter. Every slave receives the same one-cycle shift
//   pulse. The returned bit is shifted back into the local pattern.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   run         1 = advance ticks, 0 = hold
//   dir         0 = shift toward MSB, 1 = shift toward LSB (sampled at shift)
//   load_valid  load request
//   load_data   pattern to load
//   load_ready  load accept (low only while shift_en is high)
//   serial_in   return bit from the last slave
//   serial_out  bit sent to the first slave
//   shift_en    per-slave shift pulse
//   leds        current pattern
//   err_flag    sticky loopback mismatch
//   err_count   saturating loopback mismatch count
//
// Build option
//   RING_LOOPBACK_CHECK_EN  when defined, each returned bit is compared
//                           with the bit sent RING_LAT shifts earlier.
//                           Without it, err_flag and err_count are tied to 0.
//
// state | meaning
// IDLE  | counter held at 0, waiting for run
// RUN   | counter advancing, ticks issued
// HOLD  | counter frozen until run returns

module ring_shift_master #(
    parameter int          WIDTH    = 8,
    parameter int          TICK_DIV = 50_000_000,
    parameter int          N_SLAVE  = 2,
    parameter int          RING_LAT = 16,
    parameter logic [31:0] INIT     = 32'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               dir,
    input  logic               load_valid,
    input  logic [WIDTH-1:0]   load_data,
    output logic               load_ready,
    input  logic               serial_in,
    output logic               serial_out,
    output logic [N_SLAVE-1:0] shift_en,
    output logic [WIDTH-1:0]   leds,
    output logic               err_flag,
    output logic [15:0]        err_count
);

    localparam int             CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TC     = CW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_SLAVE-1:0] shift_en_q;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   leds_q, leds_d;
    logic               sout_q, sout_d;
    logic               tick, shift, load_acc;

    assign shift      = shift_en_q[0];
    assign load_ready = ~shift;
    assign load_acc   = load_valid & load_ready;
    // An accepted load restarts the tick period, so a tick falling on the
    // load edge is dropped along with the rest of the partial period.
    assign tick       = (state_q == S_RUN) && (cnt_q == TC) && !load_acc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = (cnt_q == TC) ? '0 : cnt_q + CW'(1);
                if (!run) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (run) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (load_acc) cnt_d = '0;
    end

    always_comb begin
        sr_d   = sr_q;
        leds_d = leds_q;
        sout_d = sout_q;
        if (load_acc) begin
            sr_d   = load_data;
            leds_d = load_data;
        end else if (shift) begin
            if (dir) begin
                sr_d   = {serial_in, sr_q[WIDTH-1:1]};
                sout_d = sr_q[0];
            end else begin
                sr_d   = {sr_q[WIDTH-2:0], serial_in};
                sout_d = sr_q[WIDTH-1];
            end
            leds_d = sr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_en_q <= '0;
            sr_q       <= INIT_W;
            leds_q     <= '0;
            sout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_en_q <= {N_SLAVE{tick}};
            sr_q       <= sr_d;
            leds_q     <= leds_d;
            sout_q     <= sout_d;
        end
    end

    assign shift_en   = shift_en_q;
    assign leds       = leds_q;
    assign serial_out = sout_q;

`ifdef RING_LOOPBACK_CHECK_EN
    localparam int WW = $clog2(RING_LAT + 1);

    // hist_q[0] is the most recently sent bit; hist_q[RING_LAT-1] is the
    // bit whose return is due at the current shift.
    logic [RING_LAT-1:0] hist_q;
    logic [WW-1:0]       warm_q;
    logic                err_flag_q;
    logic [15:0]         err_cnt_q;
    logic                mismatch;

    assign mismatch = shift && (warm_q == WW'(RING_LAT)) &&
                      (serial_in != hist_q[RING_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            warm_q     <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else if (load_acc) begin
            hist_q     <= '0;
            warm_q     <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else if (shift) begin
            hist_q <= RING_LAT'({hist_q, sout_d});
            if (warm_q != WW'(RING_LAT)) warm_q <= warm_q + WW'(1);
            if (mismatch) begin
                err_flag_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_flag  = err_flag_q;
    assign err_count = err_cnt_q;
`else
    assign err_flag  = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ring_shift_master.sv
module tb_ring_shift_master;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int NS = 2;
    localparam int RL = 3;

`ifdef RING_LOOPBACK_CHECK_EN
    localparam logic        EXP_INJ_F = 1'b1;
    localparam logic [15:0] EXP_INJ_C = 16'd1;
`else
    localparam logic        EXP_INJ_F = 1'b0;
    localparam logic [15:0] EXP_INJ_C = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, dir, load_valid, serial_in;
    logic [W-1:0]  load_data;
    logic          load_ready, serial_out, err_flag;
    logic [NS-1:0] shift_en;
    logic [W-1:0]  leds;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    ring_shift_master #(
        .WIDTH(W), .TICK_DIV(TD), .N_SLAVE(NS), .RING_LAT(RL), .INIT(32'd1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .dir(dir),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .serial_in(serial_in), .serial_out(serial_out), .shift_en(shift_en),
        .leds(leds), .err_flag(err_flag), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: tick position is the count of clock edges spent in
    // RUN since the last restart; the pattern is kept as an integer and
    // the sent bits in an unbounded queue.
    bit          m_running;
    int          m_acc;
    bit          m_pulse;
    logic [W-1:0] m_sr, m_leds;
    logic        m_sout;
    bit          m_errf;
    int          m_errc;
    bit          sentq[$];
    bit          ringq[$];

    function automatic void model_reset();
        m_running = 0; m_acc = 0; m_pulse = 0;
        m_sr = W'(1); m_leds = '0; m_sout = 1'b0;
        m_errf = 0; m_errc = 0;
        sentq.delete();
    endfunction

    function automatic void model_edge();
        bit load_acc;
        bit new_pulse;
        bit sent;
        load_acc  = load_valid && !m_pulse;
        new_pulse = 0;
        if (load_acc) m_acc = 0;
        else if (m_running) begin
            m_acc++;
            new_pulse = (m_acc % TD) == 0;
        end
        if (m_pulse) begin
            sent = dir ? m_sr[0] : m_sr[W-1];
            if (dir) m_sr = (m_sr >> 1) | (W'(serial_in) << (W - 1));
            else     m_sr = (m_sr << 1) | W'(serial_in);
            m_leds = m_sr;
            m_sout = sent;
`ifdef RING_LOOPBACK_CHECK_EN
            if (sentq.size() >= RL && serial_in !== sentq[sentq.size() - RL]) begin
                m_errf = 1;
                if (m_errc < 65535) m_errc++;
            end
`endif
            sentq.push_back(sent);
        end
        if (load_acc) begin
            m_sr = load_data; m_leds = load_data;
            sentq.delete(); m_errf = 0; m_errc = 0;
        end
        m_pulse   = new_pulse;
        m_running = run;
    endfunction

    function automatic logic [28:0] expv();
        logic [15:0] c;
        c = m_errc[15:0];
        return {m_leds, {NS{m_pulse}}, ~m_pulse, m_sout, m_errf, c};
    endfunction

    function automatic logic [28:0] obsv();
        return {leds, shift_en, load_ready, serial_out, err_flag, err_count};
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        run = 0; dir = 0; load_valid = 0; load_data = '0; serial_in = 0;
        do_reset();
        checks++;
        if (obsv() !== expv()) begin
            errors++; $display("FAIL reset_release got %h expected %h", obsv(), expv());
        end
        run = 1;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (leds !== 8'h00 || shift_en !== 2'b00 || err_count !== 16'h0 || err_flag !== 1'b0 ||
            serial_out !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_outputs got leds=%h en=%b cnt=%h flag=%b so=%b rdy=%b expected 00 00 0000 0 0 1",
                     leds, shift_en, err_count, err_flag, serial_out, load_ready);
        end
        checks++;
        if (dut.sr_q !== 8'h01 || dut.cnt_q !== '0) begin
            errors++; $display("FAIL async_reset_state got sr=%h cnt=%0d expected sr=01 cnt=0", dut.sr_q, dut.cnt_q);
        end
        model_reset();
        run = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tick_timing();
        int first, npulse;
        first = 0; npulse = 0;
        run = 1;
        for (int s = 1; s <= 20; s++) begin
            step();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL tick_vec step %0d got %h expected %h", s, obsv(), expv());
            end
            if (shift_en === 2'b11) begin
                npulse++;
                if (first == 0) first = s;
            end
        end
        checks++;
        if (first != 5 || npulse != 4) begin
            errors++; $display("FAIL tick_first_pulse got step %0d count %0d expected step 5 count 4", first, npulse);
        end
        run = 0;
        step();
        checks++;
        if (shift_en !== 2'b11) begin
            errors++; $display("FAIL run_fall_on_tick got %b expected 11", shift_en);
        end
        npulse = 0;
        for (int s = 0; s < 10; s++) begin
            step();
            checks++;
            if (obsv() !== expv() || dut.cnt_q !== 2'(m_acc % TD)) begin
                errors++; $display("FAIL hold_vec step %0d got %h cnt %0d expected %h cnt %0d",
                                   s, obsv(), dut.cnt_q, expv(), m_acc % TD);
            end
            if (shift_en !== 2'b00) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            errors++; $display("FAIL hold_no_pulse got %0d pulses expected 0", npulse);
        end
        run = 1;
        for (int s = 0; s < 12; s++) begin
            step();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL resume_vec step %0d got %h expected %h", s, obsv(), expv());
            end
        end
    endtask

    task automatic test_rotation();
        int n;
        bit was;
        do_reset();
        model_reset();
        dir = 0; serial_in = 0; run = 1;
        n = 0;
        for (int s = 0; s < 60 && n < 9; s++) begin
            was = m_pulse;
            step();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL rot_vec step %0d got %h expected %h", s, obsv(), expv());
            end
            if (was) begin
                n++;
                checks++;
                if (leds !== ((n <= 7) ? (8'h01 << n) : 8'h00)) begin
                    errors++; $display("FAIL rot_left shift %0d got %h expected %h", n, leds,
                                       (n <= 7) ? (8'h01 << n) : 8'h00);
                end
            end
        end
        for (int s = 0; s < 10 && m_pulse; s++) step();
        dir = 1; load_valid = 1; load_data = 8'h80;
        step();
        load_valid = 0;
        checks++;
        if (leds !== 8'h80) begin
            errors++; $display("FAIL rot_load got %h expected 80", leds);
        end
        n = 0;
        for (int s = 0; s < 60 && n < 8; s++) begin
            was = m_pulse;
            step();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL rotr_vec step %0d got %h expected %h", s, obsv(), expv());
            end
            if (was) begin
                n++;
                checks++;
                if (leds !== (8'h80 >> n)) begin
                    errors++; $display("FAIL rot_right shift %0d got %h expected %h", n, leds, 8'h80 >> n);
                end
            end
        end
    endtask

    task automatic test_load_collision();
        int k;
        bit found;
        found = 0;
        for (int s = 0; s < 20 && !found; s++) begin
            if (shift_en === 2'b11) found = 1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL coll_wait_pulse got none expected pulse within 20 cycles");
        end
        load_valid = 1; load_data = 8'hA5;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL coll_ready_low got %b expected 0", load_ready);
        end
        step();
        checks++;
        if (load_ready !== 1'b1 || obsv() !== expv()) begin
            errors++; $display("FAIL coll_reject got rdy %b vec %h expected 1 %h", load_ready, obsv(), expv());
        end
        step();
        load_valid = 0;
        checks++;
        if (leds !== 8'hA5) begin
            errors++; $display("FAIL coll_accept got %h expected a5", leds);
        end
        k = 0;
        for (int s = 1; s <= 10 && k == 0; s++) begin
            step();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL coll_vec step %0d got %h expected %h", s, obsv(), expv());
            end
            if (shift_en === 2'b11) k = s;
        end
        checks++;
        if (k != 4) begin
            errors++; $display("FAIL coll_next_tick got %0d cycles expected 4", k);
        end
    endtask

    task automatic test_loopback();
        int  nshift;
        bit  was, sin;
        do_reset();
        model_reset();
        run = 0; dir = 1'($urandom); load_valid = 1; load_data = 8'($urandom);
        step();
        load_valid = 0;
        ringq.delete();
        run = 1;
        nshift = 0;
        for (int s = 0; s < 200 && nshift < 24; s++) begin
            sin = (ringq.size() >= RL) ? ringq[ringq.size() - RL] : 1'b0;
            if (m_pulse && nshift == 20) sin = ~sin;
            serial_in = sin;
            was = m_pulse;
            step();
            if (was) begin
                nshift++;
                ringq.push_back(serial_out);
                if (nshift == 20) begin
                    checks++;
                    if (err_count !== 16'd0 || err_flag !== 1'b0) begin
                        errors++; $display("FAIL loop_clean got flag %b count %0d expected 0 0", err_flag, err_count);
                    end
                end
            end
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL loop_vec step %0d got %h expected %h", s, obsv(), expv());
            end
        end
        checks++;
        if (nshift != 24 || err_flag !== EXP_INJ_F || err_count !== EXP_INJ_C) begin
            errors++; $display("FAIL loop_inject got shifts %0d flag %b count %0d expected 24 %b %0d",
                               nshift, err_flag, err_count, EXP_INJ_F, EXP_INJ_C);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 400; s++) begin
            run        = ($urandom % 8) != 0;
            dir        = 1'($urandom);
            load_valid = ($urandom % 10) == 0;
            load_data  = 8'($urandom);
            serial_in  = 1'($urandom);
            step();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL rand_vec step %0d got %h expected %h", s, obsv(), expv());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tick_timing();
        test_rotation();
        test_load_collision();
        test_loopback();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
